// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into header,
// instruction and data words, writes the memories, then runs and supervises cpu2.
module prog_loader #(
  parameter int I_ADDR_W = 8,
  parameter int D_ADDR_W = 8,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [7:0]          in_byte,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                imem_we,
  output logic [I_ADDR_W-1:0] imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                dmem_we,
  output logic [D_ADDR_W-1:0] dmem_addr,
  output logic [31:0]         dmem_wdata,
  output logic                cpu_rst_,
  input  logic                halt,
  input  logic                exception,
  output logic                done,
  output logic [1:0]          status,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [2:0] {HDR, LOAD_I, LOAD_D, SETTLE, RUN, DONE, ERR} state_t;

  localparam logic [16:0] I_MAX = 17'(1) << I_ADDR_W;
  localparam logic [16:0] D_MAX = 17'(1) << D_ADDR_W;

  state_t      state;
  logic [1:0]  lane;
  logic [23:0] shreg;
  logic [15:0] i_cnt;
  logic [15:0] d_cnt;
  logic [16:0] widx;
  logic        xfer;
  logic        last_byte;
  logic [31:0] word;
  logic        wr_busy;

  // Bytes are refused during a write-strobe cycle so the state decision after
  // each word sees the retired strobe before the next byte arrives.
  assign wr_busy   = imem_we | dmem_we;
  assign in_ready  = !rst_ && ((state == HDR) ||
                     (((state == LOAD_I) || (state == LOAD_D)) && !wr_busy));
  assign xfer      = in_valid & in_ready;
  assign last_byte = xfer && (lane == 2'd3);
  assign word      = {in_byte, shreg};

  always_ff @(posedge clk) begin
    if (rst_) begin
      state       <= HDR;
      lane        <= 2'd0;
      shreg       <= 24'd0;
      i_cnt       <= 16'd0;
      d_cnt       <= 16'd0;
      widx        <= 17'd0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= 32'd0;
      cpu_rst_    <= 1'b0;
      done        <= 1'b0;
      status      <= 2'b00;
      cycle_count <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      if (xfer) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    shreg[7:0]   <= in_byte;
          2'd1:    shreg[15:8]  <= in_byte;
          2'd2:    shreg[23:16] <= in_byte;
          default: ;
        endcase
      end
      case (state)
        HDR: begin
          if (last_byte) begin
            i_cnt <= word[31:16];
            d_cnt <= word[15:0];
            widx  <= 17'd0;
            if (({1'b0, word[31:16]} > I_MAX) || ({1'b0, word[15:0]} > D_MAX)) begin
              state  <= ERR;
              done   <= 1'b1;
              status <= 2'b11;
            end else if (word[31:16] != 16'd0) begin
              state <= LOAD_I;
            end else if (word[15:0] != 16'd0) begin
              state <= LOAD_D;
            end else begin
              state <= SETTLE;
            end
          end
        end
        LOAD_I: begin
          if (last_byte) begin
            imem_we    <= 1'b1;
            imem_addr  <= widx[I_ADDR_W-1:0];
            imem_wdata <= word;
            widx       <= widx + 17'd1;
          end else if (imem_we && (widx == {1'b0, i_cnt})) begin
            widx  <= 17'd0;
            state <= (d_cnt != 16'd0) ? LOAD_D : SETTLE;
          end
        end
        LOAD_D: begin
          if (last_byte) begin
            dmem_we    <= 1'b1;
            dmem_addr  <= widx[D_ADDR_W-1:0];
            dmem_wdata <= word;
            widx       <= widx + 17'd1;
          end else if (dmem_we && (widx == {1'b0, d_cnt})) begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          state    <= RUN;
          cpu_rst_ <= 1'b1;
        end
        RUN: begin
          if (halt || exception) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_rst_ <= 1'b0;
            status   <= halt ? 2'b01 : 2'b10;
          end else if (cycle_count != {CNT_W{1'b1}}) begin
            cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE:    ;
        ERR:     ;
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected write sequences and run results
// are derived from the generated program stream and the chosen halt point.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        cpu_rst_;
  logic        halt = 1'b0;
  logic        exception = 1'b0;
  logic        done;
  logic [1:0]  status;
  logic [31:0] cycle_count;

  prog_loader #(.I_ADDR_W(8), .D_ADDR_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_(rst_), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_rst_(cpu_rst_), .halt(halt), .exception(exception),
    .done(done), .status(status), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  bit last_we_valid = 1'b0;
  int rise_cyc = 0;
  bit prev_cpu = 1'b0;
  logic [47:0] exp_i[$];
  logic [47:0] exp_d[$];
  logic [31:0] iw[$];
  logic [31:0] dw[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // cycle counter used to measure strobe-to-release latency
  always @(posedge clk) cyc <= cyc + 1;

  // compare process: every write strobe must match the next expected word
  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst_) begin
      if (imem_we) begin
        if (exp_i.size() == 0) chk("imem_we_unexpected", {63'd0, imem_we}, 64'd0);
        else begin
          e = exp_i.pop_front();
          chk("imem_addr", {56'd0, imem_addr}, {48'd0, e[47:32]});
          chk("imem_wdata", {32'd0, imem_wdata}, {32'd0, e[31:0]});
          chk("cpu_held_imem", {63'd0, cpu_rst_}, 64'd0);
        end
        last_we_cyc = cyc;
        last_we_valid = 1'b1;
      end
      if (dmem_we) begin
        if (exp_d.size() == 0) chk("dmem_we_unexpected", {63'd0, dmem_we}, 64'd0);
        else begin
          e = exp_d.pop_front();
          chk("dmem_addr", {56'd0, dmem_addr}, {48'd0, e[47:32]});
          chk("dmem_wdata", {32'd0, dmem_wdata}, {32'd0, e[31:0]});
          chk("cpu_held_dmem", {63'd0, cpu_rst_}, 64'd0);
        end
        last_we_cyc = cyc;
        last_we_valid = 1'b1;
      end
      if (cpu_rst_ && !prev_cpu) rise_cyc = cyc;
    end
    prev_cpu = cpu_rst_;
  end

  task automatic do_reset();
    rst_ = 1'b1; in_valid = 1'b0; halt = 1'b0; exception = 1'b0;
    @(negedge clk);
    chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_ = 1'b0;
    last_we_valid = 1'b0;
    @(negedge clk);
    chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
    chk("rst_addrs", {48'd0, imem_addr, dmem_addr}, 64'd0);
    chk("rst_wdata", {imem_wdata, dmem_wdata}, 64'd0);
    chk("rst_cpu_done_status", {60'd0, cpu_rst_, done, status}, 64'd0);
    chk("rst_cycle_count", {32'd0, cycle_count}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin in_byte = 8'($urandom); @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_byte = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL in_ready_timeout: byte %0h not accepted after %0d cycles", b, t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), gaps);
  endtask

  // expectations come straight from the stream contents: word k lands at address k
  task automatic load(input bit gaps);
    logic [31:0] hdr;
    hdr = {16'(iw.size()), 16'(dw.size())};
    for (int k = 0; k < iw.size(); k++) exp_i.push_back({16'(k), iw[k]});
    for (int k = 0; k < dw.size(); k++) exp_d.push_back({16'(k), dw[k]});
    send_word(hdr, gaps);
    foreach (iw[k]) send_word(iw[k], gaps);
    foreach (dw[k]) send_word(dw[k], gaps);
    halt = 1'b0; exception = 1'b0;
  endtask

  task automatic run_stop(input int n, input bit h, input bit e);
    int t = 0;
    @(negedge clk);
    while (!cpu_rst_ && t < 50) begin @(negedge clk); t++; end
    if (!cpu_rst_) begin
      errors++; checks++;
      $display("FAIL run_start_timeout: cpu_rst_ still %0b after %0d cycles", cpu_rst_, t);
    end else begin
      chk("load_done_imem", 64'(exp_i.size()), 64'd0);
      chk("load_done_dmem", 64'(exp_d.size()), 64'd0);
      chk("done_during_run", {63'd0, done}, 64'd0);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        chk("cpu_released", {63'd0, cpu_rst_}, 64'd1);
      end
      halt = h; exception = e;
      @(posedge clk); #1;
      halt = 1'b0; exception = 1'b0;
      @(negedge clk);
      chk("done", {63'd0, done}, 64'd1);
      chk("status", {62'd0, status}, h ? 64'd1 : 64'd2);
      chk("cycle_count", {32'd0, cycle_count}, 64'(n));
      chk("cpu_frozen", {63'd0, cpu_rst_}, 64'd0);
      halt = 1'($urandom); exception = 1'($urandom);
      repeat (3) @(negedge clk);
      chk("done_hold", {61'd0, done, status}, {61'd0, 1'b1, (h ? 2'd1 : 2'd2)});
      chk("count_hold", {32'd0, cycle_count}, 64'(n));
      chk("cpu_stays_frozen", {63'd0, cpu_rst_}, 64'd0);
      if (last_we_valid) chk("release_delay", 64'(rise_cyc - last_we_cyc), 64'd2);
      halt = 1'b0; exception = 1'b0;
    end
  endtask

  task automatic set_test1();
    iw.delete(); dw.delete();
    iw.push_back(32'h20010005); iw.push_back(32'hAC010000);
    dw.push_back(32'hDEADBEEF);
  endtask

  task automatic err_header(input logic [31:0] hdr);
    send_word(hdr, 1'b0);
    @(negedge clk);
    chk("err_done_status", {61'd0, done, status}, {61'd0, 3'b111});
    chk("err_cpu", {63'd0, cpu_rst_}, 64'd0);
    in_valid = 1'b1; halt = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("err_in_ready", {63'd0, in_ready}, 64'd0);
    end
    chk("err_sticky", {61'd0, done, status}, {61'd0, 3'b111});
    in_valid = 1'b0; halt = 1'b0;
  endtask

  initial begin
    // test 1: literal stream, halt in the 11th RUN cycle
    do_reset();
    set_test1();
    load(1'b0);
    run_stop(10, 1'b1, 1'b0);

    // test 2 + 4: same stream with gaps, halt/exception tie then exception only
    do_reset(); set_test1(); load(1'b1); run_stop(4, 1'b1, 1'b1);
    do_reset(); set_test1(); load(1'b1); run_stop(7, 1'b0, 1'b1);

    // test 5: oversize counts go to the error state with no writes
    do_reset(); err_header(32'h01010000);
    do_reset(); err_header(32'h00000101);

    // test 6: reset in the middle of the second imem word, then resend
    do_reset();
    exp_i.push_back({16'd0, 32'h20010005});
    send_word(32'h00020001, 1'b0);
    send_word(32'h20010005, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    do_reset();
    chk("partial_flushed", 64'(exp_i.size()), 64'd0);
    set_test1(); load(1'b0); run_stop(10, 1'b1, 1'b0);

    // full-depth imem, halt in the first RUN cycle, empty program
    do_reset();
    iw.delete(); dw.delete();
    for (int k = 0; k < 256; k++) iw.push_back($urandom);
    dw.push_back($urandom);
    load(1'b0); run_stop(3, 1'b0, 1'b1);
    do_reset(); iw.delete(); dw.delete(); load(1'b1); run_stop(0, 1'b1, 1'b0);

    // randomized programs; halt/exception also driven during load to show they are ignored
    for (int it = 0; it < 8; it++) begin
      int ni, nd, n;
      logic [1:0] he;
      do_reset();
      iw.delete(); dw.delete();
      ni = $urandom_range(0, 6); nd = $urandom_range(0, 6);
      for (int k = 0; k < ni; k++) iw.push_back($urandom);
      for (int k = 0; k < nd; k++) dw.push_back($urandom);
      halt = 1'($urandom); exception = 1'($urandom);
      n = $urandom_range(0, 25);
      he = 2'($urandom_range(1, 3));
      load(1'($urandom));
      run_stop(n, he[1], he[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
